// File: rtl/hyp_lut_pkg.sv
// Shared mode encoding, counter width and the elaboration-time table generator
// for the hyperbolic lookup pipeline.
package hyp_lut_pkg;

    typedef enum logic {
        MODE_COSH = 1'b0,
        MODE_SINH = 1'b1
    } hyp_mode_e;

    localparam int SAT_CNT_W = 16;

    // Unclamped round-half-up of f(idx / 2^in_frac) * 2^out_frac; large values
    // are pinned well above any realistic MAXV so the int conversion cannot overflow.
    function automatic int hyp_raw(input int idx, input int in_frac, input int out_frac,
                                   input bit is_sinh);
        real x;
        real f;
        real scaled;
        x      = real'(idx) / real'(1 << in_frac);
        f      = is_sinh ? $sinh(x) : $cosh(x);
        scaled = $floor(f * real'(1 << out_frac) + 0.5);
        if (scaled > 1.0e9) begin
            return 1000000000;
        end
        return int'(scaled);
    endfunction

endpackage

// File: rtl/hyp_lut_if.sv
// Valid/ready operand and result channels of the hyperbolic lookup pipeline.
interface hyp_lut_if #(
    parameter int IN_W  = 7,
    parameter int OUT_W = 10
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_x;
    logic             in_mode;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_y;
    logic             out_sat;

    modport master (
        output in_valid, in_x, in_mode, out_ready,
        input  in_ready, out_valid, out_y, out_sat
    );

    modport slave (
        input  in_valid, in_x, in_mode, out_ready,
        output in_ready, out_valid, out_y, out_sat
    );
endinterface

// File: rtl/hyp_lut_rom.sv
// Registered-read ROM of |f(x)| magnitudes, clamped to MAXV, with a per-entry
// sat flag; contents are generated from hyp_raw at elaboration.
module hyp_lut_rom
    import hyp_lut_pkg::*;
#(
    parameter int IN_W     = 7,
    parameter int IN_FRAC  = 4,
    parameter int OUT_W    = 10,
    parameter int OUT_FRAC = 5,
    parameter bit IS_SINH  = 1'b0
) (
    input  logic             clk,
    input  logic             en,
    input  logic [IN_W-1:0]  addr,
    output logic [OUT_W-2:0] mag_q,
    output logic             sat_q
);
    localparam int               DEPTH  = (1 << (IN_W - 1)) + 1;
    localparam int               MAXV_I = (1 << (OUT_W - 1)) - 1;
    localparam logic [OUT_W-2:0] MAXV   = '1;

    logic [OUT_W-2:0] mag_tbl [DEPTH];
    logic             sat_tbl [DEPTH];
    logic [OUT_W-2:0] mag_d;
    logic             sat_d;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_tbl
            assign sat_tbl[gi] = hyp_raw(gi, IN_FRAC, OUT_FRAC, IS_SINH) > MAXV_I;
            assign mag_tbl[gi] = sat_tbl[gi] ? MAXV
                               : (OUT_W-1)'(hyp_raw(gi, IN_FRAC, OUT_FRAC, IS_SINH));
        end
    endgenerate

    always_comb begin
        mag_d = mag_tbl[addr];
        sat_d = sat_tbl[addr];
    end

    always_ff @(posedge clk) begin
        if (en) begin
            mag_q <= mag_d;
            sat_q <= sat_d;
        end
    end
endmodule

// File: rtl/hyp_lut_pipe.sv
// Three-stage cosh/sinh lookup pipeline with global stall and saturation counter.
// Define HYP_LUT_SINH_EN to compile in the sinh table and honour in_mode.
module hyp_lut_pipe
    import hyp_lut_pkg::*;
#(
    parameter int IN_W     = 7,
    parameter int IN_FRAC  = 4,
    parameter int OUT_W    = 10,
    parameter int OUT_FRAC = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hyp_lut_if.slave             bus,
    input  logic                 sat_clr,
    output logic [SAT_CNT_W-1:0] sat_cnt
);
    logic stall;

    logic             v1_q, v1_d, neg1_q, neg1_d;
    logic [IN_W-1:0]  abs1_q, abs1_d, abs_x;
    hyp_mode_e        mode1_q, mode1_d, mode2_q, mode2_d;
    logic             v2_q, v2_d, neg2_q, neg2_d;
    logic             out_valid_q, out_valid_d, out_sat_q, out_sat_d;
    logic [OUT_W-1:0] out_y_q, out_y_d;
    logic [SAT_CNT_W-1:0] sat_cnt_q, sat_cnt_d;

    logic [OUT_W-2:0] cosh_mag, sel_mag;
    logic             cosh_sat, sel_sat, apply_neg;
    logic [OUT_W-1:0] y_s2;

    assign stall        = out_valid_q && !bus.out_ready;
    assign bus.in_ready = !stall;

    hyp_lut_rom #(.IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC),
                  .IS_SINH(1'b0)) u_cosh_rom (
        .clk(clk), .en(!stall), .addr(abs1_q), .mag_q(cosh_mag), .sat_q(cosh_sat)
    );

`ifdef HYP_LUT_SINH_EN
    logic [OUT_W-2:0] sinh_mag;
    logic             sinh_sat;

    hyp_lut_rom #(.IN_W(IN_W), .IN_FRAC(IN_FRAC), .OUT_W(OUT_W), .OUT_FRAC(OUT_FRAC),
                  .IS_SINH(1'b1)) u_sinh_rom (
        .clk(clk), .en(!stall), .addr(abs1_q), .mag_q(sinh_mag), .sat_q(sinh_sat)
    );

    always_comb begin
        sel_mag   = (mode2_q == MODE_SINH) ? sinh_mag : cosh_mag;
        sel_sat   = (mode2_q == MODE_SINH) ? sinh_sat : cosh_sat;
        apply_neg = (mode2_q == MODE_SINH) && neg2_q;
        mode1_d   = hyp_mode_e'(bus.in_mode);
    end
`else
    logic sinh_unused;
    assign sinh_unused = ^{bus.in_mode, neg2_q, mode2_q};

    always_comb begin
        sel_mag   = cosh_mag;
        sel_sat   = cosh_sat;
        apply_neg = 1'b0;
        mode1_d   = MODE_COSH;
    end
`endif

    // Magnitude is at most MAXV, so negation stays within the symmetric range.
    assign y_s2  = apply_neg ? -{1'b0, sel_mag} : {1'b0, sel_mag};
    assign abs_x = bus.in_x[IN_W-1] ? -bus.in_x : bus.in_x;

    always_comb begin
        v1_d        = v1_q;
        neg1_d      = neg1_q;
        abs1_d      = abs1_q;
        v2_d        = v2_q;
        neg2_d      = neg2_q;
        mode2_d     = mode2_q;
        out_valid_d = out_valid_q;
        out_y_d     = out_y_q;
        out_sat_d   = out_sat_q;
        if (!stall) begin
            v1_d        = bus.in_valid;
            neg1_d      = bus.in_x[IN_W-1];
            abs1_d      = abs_x;
            v2_d        = v1_q;
            neg2_d      = neg1_q;
            mode2_d     = mode1_q;
            out_valid_d = v2_q;
            out_y_d     = y_s2;
            out_sat_d   = sel_sat;
        end
        sat_cnt_d = sat_cnt_q;
        if (sat_clr) begin
            sat_cnt_d = '0;
        end else if (out_valid_q && bus.out_ready && out_sat_q && (sat_cnt_q != '1)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            neg1_q      <= 1'b0;
            abs1_q      <= '0;
            mode1_q     <= MODE_COSH;
            v2_q        <= 1'b0;
            neg2_q      <= 1'b0;
            mode2_q     <= MODE_COSH;
            out_valid_q <= 1'b0;
            out_y_q     <= '0;
            out_sat_q   <= 1'b0;
            sat_cnt_q   <= '0;
        end else begin
            v1_q        <= v1_d;
            neg1_q      <= neg1_d;
            abs1_q      <= abs1_d;
            mode1_q     <= mode1_d;
            v2_q        <= v2_d;
            neg2_q      <= neg2_d;
            mode2_q     <= mode2_d;
            out_valid_q <= out_valid_d;
            out_y_q     <= out_y_d;
            out_sat_q   <= out_sat_d;
            sat_cnt_q   <= sat_cnt_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.out_y     = out_y_q;
    assign bus.out_sat   = out_sat_q;
    assign sat_cnt       = sat_cnt_q;
endmodule

// File: doc/hyp_lut_pipe.md
HYP_LUT_PIPE -- requirements
Module: hyp_lut_pipe

Interface
REQ-001 Parameter IN_W, default 7, input width, signed fixed point.
REQ-002 Parameter IN_FRAC, default 4, input fractional bits.
REQ-003 Parameter OUT_W, default 10, output width, signed fixed point.
REQ-004 Parameter OUT_FRAC, default 5, output fractional bits.
REQ-005 clk  input  1  single clock; all state on rising edge.
REQ-006 rst_n  input  1  reset; synchronous and active-low.
REQ-007 in_valid  input  1  in_x/in_mode valid this cycle.
REQ-008 in_ready  output  1  block accepts input this cycle.
REQ-009 in_x  input  IN_W  operand, two's complement.
REQ-010 in_mode  input  1  0 = cosh, 1 = sinh.
REQ-011 out_valid  output  1  out_y/out_sat valid.
REQ-012 out_ready  input  1  consumer accepts output.
REQ-013 out_y  output  OUT_W  result, two's complement, OUT_FRAC fractional bits.
REQ-014 out_sat  output  1  out_y was clamped.
REQ-015 sat_clr  input  1  clears sat_cnt.
REQ-016 sat_cnt  output  16  count of delivered saturated results.

Function
REQ-017 Transfer occurs on in_valid && in_ready (input) and out_valid && out_ready (output).
REQ-018 Three-stage pipeline: S1 registers sign, |in_x|, mode. S2 registers table read. S3 applies sign, clamps and registers.
REQ-019 Latency SHALL be exactly 3 cycles from input transfer to out_valid when not stalled; throughput is one result per cycle.
REQ-020 Global stall: stall = out_valid && !out_ready; in_ready = !stall. All stages hold while stalled, with no loss or duplication.
REQ-021 |in_x| SHALL be computed at IN_W bits unsigned, so the most negative input (-2^(IN_W-1-IN_FRAC)) is exact.
REQ-022 Table depth SHALL be 2^(IN_W-1)+1 entries, indexed by |in_x|.
REQ-023 Each entry SHALL be round-half-up(f(|x|) * 2^OUT_FRAC), computed at elaboration.
REQ-024 Entries SHALL be clamped to MAXV = 2^(OUT_W-1)-1, with a per-entry sat bit set when clamped.
REQ-025 Cosh mode: out_y = entry, regardless of the input sign.
REQ-026 Sinh mode: out_y = entry for x >= 0 and -entry for x < 0. The output range is symmetric, [-MAXV, +MAXV]; -2^(OUT_W-1) is never produced.
REQ-027 Results SHALL never wrap; out_sat = 1 exactly when the clamp applied.
REQ-028 sat_cnt SHALL increment on each output transfer with out_sat = 1 and hold at 0xFFFF (saturating).
REQ-029 If sat_clr and an increment occur in the same cycle, sat_clr wins and sat_cnt = 0.
REQ-030 in_mode SHALL travel with its operand, so a mode change takes effect per transaction.

Reset
REQ-031 While rst_n = 0 at a clock edge: all stage valids, out_valid, out_y, out_sat and sat_cnt SHALL be set to 0, and in_ready SHALL be 1 on the first cycle after release.
REQ-032 Reset mid-operation SHALL flush all in-flight transactions; none are emitted after release.

Configuration
REQ-033 With HYP_LUT_SINH_EN defined: sinh table and mode are compiled in, as in REQ-026.
REQ-034 With HYP_LUT_SINH_EN undefined: only the cosh table exists, in_mode is ignored and treated as 0, and latency and handshake are unchanged.

Structure
REQ-035 Package hyp_lut_pkg SHALL hold mode constants MODE_COSH=0 and MODE_SINH=1, SAT_CNT_W=16, and the elaboration-time table-generation function.
REQ-036 Sub-module hyp_lut_rom SHALL be a parametrised, registered-read ROM (stage S2) with a per-entry sat bit, instantiated once per compiled-in function.

Verification (defaults)
REQ-037 Cosh: x = 0x00, 0x10, 0x20, 0x30 (0, 1, 2, 3) -> y = 32, 49, 120, 322; sat = 0; each arrives 3 cycles after acceptance.
REQ-038 Saturation: cosh at x = 0x38 (3.5) and 0x40 (-4) -> y = 511, sat = 1; sat_cnt = 2; sat_clr pulsed with a third saturated output in the same cycle -> sat_cnt = 0.
REQ-039 Sinh (macro defined): x = 0x10 -> 38; x = 0x70 (-1) -> -38; x = 0x40 (-4) -> -511, sat = 1.
REQ-040 Backpressure: 10 back-to-back inputs with out_ready toggling randomly -> 10 in-order outputs matching the model, and in_ready = 0 exactly in stall cycles.
REQ-041 Reset mid-stream: rst_n low for 1 cycle with 3 transactions in flight -> next cycle out_valid = 0, sat_cnt = 0, and no stale output after release.
